// File: rtl/opb_reg_pkg.sv
// Shared types and helpers for the OPB control-word register and its ack sequencer.
package opb_reg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACK  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

    localparam logic [DATA_W-1:0] OFF_DATA  = 32'h0000_0000;
    localparam logic [DATA_W-1:0] OFF_WRCNT = 32'h0000_0004;

    // Byte-lane merge; be[3] gates the most significant byte.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] dbus,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = dbus[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and IDLE/ACK/HOLD acknowledge sequencer.
module opb_slave_ack_fsm
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_0300,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_03FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select,
    input  logic        seq_addr,
    input  logic [31:0] abus,
    output logic        xfer_ack,
    output logic        enter_ack_c
);

    state_t state;
    state_t next_state;
    logic   hit_c;

    assign hit_c = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            xfer_ack <= 1'b0;
        end else begin
            state    <= next_state;
            xfer_ack <= (next_state == ST_ACK);
        end
    end

    // HOLD keeps a lingering select from being acknowledged a second time.
    always_comb begin
        next_state  = state;
        enter_ack_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hit_c) begin
                    next_state  = ST_ACK;
                    enter_ack_c = 1'b1;
                end
            end
            ST_ACK: begin
                if (seq_addr || !select) begin
                    next_state = ST_IDLE;
                end else begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!select) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_ppc2fabric.sv
// OPB slave control register written by the PPC and read by fabric logic, with a write counter.
module opb_register_ppc2fabric
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_0300,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100_03FF,
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter string       C_FAMILY      = "virtex6",
    parameter logic [31:0] C_RESET_VALUE = 32'h0000_0000
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst,
    input  logic [0:31] OPB_ABus,
    input  logic [0:3]  OPB_BE,
    input  logic [0:31] OPB_DBus,
    input  logic        OPB_RNW,
    input  logic        OPB_select,
    input  logic        OPB_seqAddr,
    output logic [0:31] Sl_DBus,
    output logic        Sl_xferAck,
    output logic        Sl_errAck,
    output logic        Sl_retry,
    output logic        Sl_toutSup,
    output logic [31:0] user_data_out,
    output logic        user_update
);

    if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32) begin : g_bad_width
        $error("opb_register_ppc2fabric supports only 32-bit OPB address and data");
    end
    if (C_FAMILY == "") begin : g_no_family
        $error("C_FAMILY must name a device family");
    end

    logic [DATA_W-1:0] abus_w;
    logic [DATA_W-1:0] dbus_w;
    logic [BE_W-1:0]   be_w;
    logic [DATA_W-1:0] offset_c;
    logic [DATA_W-1:0] rd_mux_c;
    logic [DATA_W-1:0] wr_count;
    logic              enter_ack_c;
    logic              wr_data_c;

    // Big-endian OPB vectors map positionally: bus bit 0 becomes word bit 31.
    assign abus_w = OPB_ABus;
    assign dbus_w = OPB_DBus;
    assign be_w   = OPB_BE;

    assign offset_c = (abus_w - C_BASEADDR) & ~32'd3;

    opb_slave_ack_fsm #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_ack_fsm (
        .clk         (OPB_Clk),
        .rst         (OPB_Rst),
        .select      (OPB_select),
        .seq_addr    (OPB_seqAddr),
        .abus        (abus_w),
        .xfer_ack    (Sl_xferAck),
        .enter_ack_c (enter_ack_c)
    );

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    assign wr_data_c = enter_ack_c && !OPB_RNW && (offset_c == OFF_DATA) && (be_w != 4'b0000);

    always_comb begin
        rd_mux_c = '0;
        case (offset_c)
            OFF_DATA:  rd_mux_c = user_data_out;
            OFF_WRCNT: rd_mux_c = wr_count;
            default:   rd_mux_c = '0;
        endcase
    end

    // Commits land on the edge entering ACK so data and strobe line up with Sl_xferAck.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            user_data_out <= C_RESET_VALUE;
            wr_count      <= '0;
            user_update   <= 1'b0;
            Sl_DBus       <= '0;
        end else begin
            user_update <= wr_data_c;
            if (wr_data_c) begin
                user_data_out <= be_merge(user_data_out, dbus_w, be_w);
                wr_count      <= wr_count + 32'd1;
            end
            Sl_DBus <= (enter_ack_c && OPB_RNW) ? rd_mux_c : '0;
        end
    end

endmodule

// File: tb/tb_opb_register_ppc2fabric.sv
// Directed bench for the OPB control-word register: reset, writes, reads, bursts, wrap and reset during ack.
module tb_opb_register_ppc2fabric;

    localparam logic [31:0] RST_VAL = 32'hA5A5_0001;
    localparam logic [31:0] BASE    = 32'h0100_0300;

    logic        clk;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        sl_ack;
    logic        sl_err;
    logic        sl_retry;
    logic        sl_tout;
    logic [31:0] udo;
    logic        upd;

    int total = 0;
    int bad   = 0;

    opb_register_ppc2fabric #(
        .C_BASEADDR    (BASE),
        .C_HIGHADDR    (32'h0100_03FF),
        .C_OPB_AWIDTH  (32),
        .C_OPB_DWIDTH  (32),
        .C_FAMILY      ("virtex6"),
        .C_RESET_VALUE (RST_VAL)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst       (rst),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (sl_ack),
        .Sl_errAck     (sl_err),
        .Sl_retry      (sl_retry),
        .Sl_toutSup    (sl_tout),
        .user_data_out (udo),
        .user_update   (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One single-beat transfer; lat is the number of cycles to ack (8 means no ack).
    task automatic xfer(input logic [31:0] addr, input logic r, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic updv, output int lat);
        @(negedge clk);
        abus = addr; rnw = r; be = b; dbus = d; seq = 1'b0; sel = 1'b1;
        lat = 0; rdata = '0; updv = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!sl_ack && lat < 8);
        if (sl_ack) begin
            rdata = sl_dbus;
            updv  = upd;
        end
        sel = 1'b0; rnw = 1'b1; be = 4'b0000; dbus = '0;
        @(negedge clk);
        chk("post_ack", 32'(sl_ack), 32'd0);
        chk("post_dbus", sl_dbus, 32'd0);
        chk("post_upd", 32'(upd), 32'd0);
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        u;
    int          lat;
    int          acks;
    int          last;

    initial begin
        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_udo", udo, RST_VAL);
        chk("rst_ack", 32'(sl_ack), 32'd0);
        chk("rst_dbus", sl_dbus, 32'd0);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_tied", {29'd0, sl_err, sl_retry, sl_tout}, 32'd0);

        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'd0, rd, u, lat);
        chk("rst_cnt_lat", 32'(lat), 32'd1);
        chk("rst_cnt", rd, 32'd0);

        xfer(BASE, 1'b0, 4'b1111, 32'hDEAD_BEEF, rd, u, lat);
        chk("w1_lat", 32'(lat), 32'd1);
        chk("w1_upd", 32'(u), 32'd1);
        chk("w1_udo", udo, 32'hDEAD_BEEF);

        xfer(BASE, 1'b0, 4'b0101, 32'h1122_3344, rd, u, lat);
        chk("w2_upd", 32'(u), 32'd1);
        chk("w2_udo", udo, 32'hDE22_BE44);

        xfer(BASE, 1'b0, 4'b0000, 32'hFFFF_FFFF, rd, u, lat);
        chk("w0be_lat", 32'(lat), 32'd1);
        chk("w0be_upd", 32'(u), 32'd0);
        chk("w0be_udo", udo, 32'hDE22_BE44);

        xfer(BASE, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("rd_data_lat", 32'(lat), 32'd1);
        chk("rd_data", rd, 32'hDE22_BE44);
        xfer(BASE + 32'd4, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("rd_cnt", rd, 32'd2);

        xfer(BASE + 32'd4, 1'b0, 4'b1111, 32'h1234_5678, rd, u, lat);
        chk("wcnt_lat", 32'(lat), 32'd1);
        chk("wcnt_upd", 32'(u), 32'd0);
        xfer(BASE + 32'd4, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("wcnt_keep", rd, 32'd2);
        chk("wcnt_udo", udo, 32'hDE22_BE44);

        xfer(BASE + 32'd8, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("rd_off8_lat", 32'(lat), 32'd1);
        chk("rd_off8", rd, 32'd0);
        xfer(32'h0100_03FF, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("rd_high_lat", 32'(lat), 32'd1);
        chk("rd_high", rd, 32'd0);

        xfer(32'h0100_0400, 1'b0, 4'b1111, 32'h0BAD_0BAD, rd, u, lat);
        chk("oow_hi_noack", 32'(lat), 32'd8);
        xfer(32'h0100_02FC, 1'b0, 4'b1111, 32'h0BAD_0BAD, rd, u, lat);
        chk("oow_lo_noack", 32'(lat), 32'd8);
        chk("oow_udo", udo, 32'hDE22_BE44);

        // Select held for 10 cycles without seqAddr.
        @(negedge clk);
        abus = BASE; rnw = 1'b1; be = 4'b1111; seq = 1'b0; sel = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sl_ack) acks++;
        end
        chk("held_acks", 32'(acks), 32'd1);
        sel = 1'b0;
        repeat (2) @(negedge clk);

        // seqAddr burst of three writes.
        @(negedge clk);
        abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'd1; seq = 1'b1; sel = 1'b1;
        acks = 0; last = 0;
        for (int c = 1; c <= 20 && acks < 3; c++) begin
            @(negedge clk);
            if (sl_ack) begin
                acks++;
                if (acks > 1) chk("burst_gap", 32'(c - last), 32'd2);
                last = c;
                if (acks < 3) dbus = 32'(acks + 1);
                else begin
                    sel = 1'b0; seq = 1'b0;
                end
            end
        end
        sel = 1'b0; seq = 1'b0;
        chk("burst_acks", 32'(acks), 32'd3);
        repeat (2) @(negedge clk);
        chk("burst_udo", udo, 32'd3);
        xfer(BASE + 32'd4, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("burst_cnt", rd, 32'd5);

        // Counter wrap.
        @(negedge clk);
        force dut.wr_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.wr_count;
        xfer(BASE, 1'b0, 4'b1111, 32'h0000_00AA, rd, u, lat);
        chk("wrap_udo", udo, 32'h0000_00AA);
        xfer(BASE + 32'd4, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("wrap_cnt", rd, 32'd0);

        // Reset asserted while the ack is showing.
        @(negedge clk);
        abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'hCAFE_F00D; seq = 1'b0; sel = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!sl_ack && lat < 8);
        chk("rstack_lat", 32'(lat), 32'd1);
        rst = 1'b1; sel = 1'b0;
        @(negedge clk);
        chk("rstack_ack", 32'(sl_ack), 32'd0);
        chk("rstack_udo", udo, RST_VAL);
        chk("rstack_upd", 32'(upd), 32'd0);
        rst = 1'b0;
        xfer(BASE + 32'd4, 1'b1, 4'b1111, 32'd0, rd, u, lat);
        chk("rstack_cnt", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
